// File: rtl/plic_target_arb.sv
// Per-target PLIC arbiter: sweeps the source gateways one ID per cycle, latches the best
// eligible source at the end of each sweep, and sequences the claim/complete handshakes.
module plic_target_arb #(
  parameter int SRC_NUM    = 31,
  parameter int PRIO_WIDTH = 3,
  parameter int ID_WIDTH   = $clog2(SRC_NUM + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [SRC_NUM-1:0]             ip_i,
  input  logic [SRC_NUM-1:0]             ie_i,
  input  logic [SRC_NUM*PRIO_WIDTH-1:0]  prio_i,
  input  logic [PRIO_WIDTH-1:0]          thold_i,
  input  logic                           claim_req_i,
  output logic                           claim_vld_o,
  output logic [ID_WIDTH-1:0]            claim_id_o,
  output logic [SRC_NUM-1:0]             claim_o,
  input  logic                           comp_req_i,
  input  logic [ID_WIDTH-1:0]            comp_id_i,
  output logic [SRC_NUM-1:0]             comp_o,
  output logic                           irq_o
);

  typedef enum logic {
    SCAN,
    BLANK
  } state_e;

  state_e                state_q, state_d;
  logic                  blankCnt_q, blankCnt_d;
  logic [ID_WIDTH-1:0]   idx_q, idx_d;
  logic [ID_WIDTH-1:0]   bestId_q, bestId_d;
  logic [PRIO_WIDTH-1:0] bestPrio_q, bestPrio_d;
  logic [ID_WIDTH-1:0]   winId_q, winId_d;
  logic                  irq_q, irq_d;
  logic                  claimVld_q, claimVld_d;
  logic [ID_WIDTH-1:0]   claimId_q, claimId_d;
  logic [SRC_NUM-1:0]    claim_q, claim_d;
  logic [SRC_NUM-1:0]    comp_q, comp_d;

  logic [SRC_NUM-1:0]    elig;
  logic [SRC_NUM-1:0]    winHot;
  logic                  winElig;
  logic [PRIO_WIDTH-1:0] curPrio;
  logic                  curElig;
  logic [ID_WIDTH-1:0]   candId;
  logic [PRIO_WIDTH-1:0] candPrio;

  // Per-source eligibility, the scanned source's view, and the one-hot of the current winner.
  always_comb begin
    elig    = '0;
    winHot  = '0;
    curPrio = '0;
    curElig = 1'b0;
    for (int k = 0; k < SRC_NUM; k++) begin
      elig[k]   = ip_i[k] & ie_i[k] & (prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > thold_i);
      winHot[k] = (winId_q == ID_WIDTH'(k + 1));
      if (idx_q == ID_WIDTH'(k + 1)) begin
        curPrio = prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
        curElig = elig[k];
      end
    end
    winElig = |(elig & winHot);
  end

  always_comb begin
    state_d    = state_q;
    blankCnt_d = blankCnt_q;
    idx_d      = idx_q;
    bestId_d   = bestId_q;
    bestPrio_d = bestPrio_q;
    winId_d    = winId_q;
    candId     = bestId_q;
    candPrio   = bestPrio_q;
    if (claim_req_i) begin
      state_d    = BLANK;
      blankCnt_d = 1'b0;
      idx_d      = ID_WIDTH'(1);
      bestId_d   = '0;
      bestPrio_d = '0;
      winId_d    = '0;
    end else begin
      unique case (state_q)
        SCAN: begin
          // Strict compare over an ascending scan keeps the lowest ID on priority ties.
          if (curElig && (curPrio > bestPrio_q)) begin
            candId   = idx_q;
            candPrio = curPrio;
          end
          if (idx_q == ID_WIDTH'(SRC_NUM)) begin
            winId_d    = candId;
            bestId_d   = '0;
            bestPrio_d = '0;
            idx_d      = ID_WIDTH'(1);
          end else begin
            bestId_d   = candId;
            bestPrio_d = candPrio;
            idx_d      = idx_q + ID_WIDTH'(1);
          end
        end
        BLANK: begin
          if (blankCnt_q) begin
            state_d = SCAN;
          end else begin
            blankCnt_d = 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Claim response, complete pulses and the registered irq line.
  always_comb begin
    irq_d      = winElig & ~claim_req_i;
    claimVld_d = claim_req_i;
    claimId_d  = claimId_q;
    claim_d    = '0;
    comp_d     = '0;
    if (claim_req_i) begin
      claimId_d = winElig ? winId_q : '0;
      claim_d   = winElig ? winHot : '0;
    end
    for (int k = 0; k < SRC_NUM; k++) begin
      comp_d[k] = comp_req_i & (comp_id_i == ID_WIDTH'(k + 1)) & ie_i[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= SCAN;
      blankCnt_q <= 1'b0;
      idx_q      <= ID_WIDTH'(1);
      bestId_q   <= '0;
      bestPrio_q <= '0;
      winId_q    <= '0;
      irq_q      <= 1'b0;
      claimVld_q <= 1'b0;
      claimId_q  <= '0;
      claim_q    <= '0;
      comp_q     <= '0;
    end else begin
      state_q    <= state_d;
      blankCnt_q <= blankCnt_d;
      idx_q      <= idx_d;
      bestId_q   <= bestId_d;
      bestPrio_q <= bestPrio_d;
      winId_q    <= winId_d;
      irq_q      <= irq_d;
      claimVld_q <= claimVld_d;
      claimId_q  <= claimId_d;
      claim_q    <= claim_d;
      comp_q     <= comp_d;
    end
  end

  assign irq_o       = irq_q;
  assign claim_vld_o = claimVld_q;
  assign claim_id_o  = claimId_q;
  assign claim_o     = claim_q;
  assign comp_o      = comp_q;

endmodule

// File: tb/tb_plic_target_arb.sv
// Scoreboard bench for plic_target_arb (8 sources): a reference arbiter predicts each claim
// and complete response, and a negedge monitor pops and compares them as the DUT emits them.
module tb_plic_target_arb;

  localparam int SRC_NUM    = 8;
  localparam int PRIO_WIDTH = 3;
  localparam int ID_WIDTH   = 4;
  localparam int SETTLE     = 24;
  localparam int IRQ_BOUND  = 2 * SRC_NUM + 2;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [7:0]  ip = '0;
  logic [7:0]  ie = '0;
  logic [23:0] prio = '0;
  logic [2:0]  thold = '0;
  logic        claimReq = 1'b0;
  logic        compReq = 1'b0;
  logic [3:0]  compId = '0;
  logic        claimVld;
  logic [3:0]  claimId;
  logic [7:0]  claimHot;
  logic [7:0]  compHot;
  logic        irq;

  int          total = 0;
  int          bad = 0;
  int          claimQ[$];
  logic [7:0]  compQ[$];
  int          expId;
  logic [7:0]  expComp;

  always #5 clk = ~clk;

  plic_target_arb #(
    .SRC_NUM   (SRC_NUM),
    .PRIO_WIDTH(PRIO_WIDTH)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rstN),
    .ip_i       (ip),
    .ie_i       (ie),
    .prio_i     (prio),
    .thold_i    (thold),
    .claim_req_i(claimReq),
    .claim_vld_o(claimVld),
    .claim_id_o (claimId),
    .claim_o    (claimHot),
    .comp_req_i (compReq),
    .comp_id_i  (compId),
    .comp_o     (compHot),
    .irq_o      (irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic int prioOf(input int k);
    return int'(prio[(k-1)*PRIO_WIDTH +: PRIO_WIDTH]);
  endfunction

  function automatic bit eligNow(input int k);
    if (k < 1 || k > SRC_NUM) return 1'b0;
    return ip[k-1] && ie[k-1] && (prioOf(k) > int'(thold));
  endfunction

  // Highest priority among eligible sources; lowest ID on ties; 0 when none.
  function automatic int refWinner();
    int best = 0;
    int bestP = 0;
    for (int k = 1; k <= SRC_NUM; k++) begin
      if (eligNow(k) && prioOf(k) > bestP) begin
        best  = k;
        bestP = prioOf(k);
      end
    end
    return best;
  endfunction

  function automatic logic [7:0] hot(input int id);
    logic [7:0] h = '0;
    for (int k = 1; k <= SRC_NUM; k++) if (id == k) h[k-1] = 1'b1;
    return h;
  endfunction

  always @(negedge clk) begin
    if (rstN) begin
      if (claimVld) begin
        if (claimQ.size() == 0) begin
          checkOutput("claim_unexpected", 32'd1, 32'd0);
        end else begin
          expId = claimQ.pop_front();
          checkOutput("claim_id", 32'(claimId), 32'(expId));
          checkOutput("claim_onehot", 32'(claimHot), 32'(hot(expId)));
        end
      end else if (claimHot != 0) begin
        checkOutput("claim_o_stray", 32'(claimHot), 32'd0);
      end
      if (compHot != 0) begin
        if (compQ.size() == 0) begin
          checkOutput("comp_unexpected", 32'(compHot), 32'd0);
        end else begin
          expComp = compQ.pop_front();
          checkOutput("comp_onehot", 32'(compHot), 32'(expComp));
        end
      end
    end
  end

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [7:0] ipV, input logic [7:0] ieV,
                               input logic [23:0] prioV, input logic [2:0] tholdV);
    ip = ipV;
    ie = ieV;
    prio = prioV;
    thold = tholdV;
    repeat (SETTLE) @(posedge clk);
    #1;
    checkOutput("irq_settled", 32'(irq), 32'(refWinner() != 0));
  endtask

  task automatic doClaim(input logic [7:0] ieAtClaim, input bit withComp, input logic [3:0] cId,
                         input bit forceZero, output int got);
    int  w;
    bit  validComp;
    w = refWinner();
    ie = ieAtClaim;
    got = (!forceZero && w != 0 && eligNow(w)) ? w : 0;
    claimQ.push_back(got);
    claimReq = 1'b1;
    validComp = 1'b0;
    if (withComp) begin
      compReq = 1'b1;
      compId = cId;
      validComp = (cId >= 1) && (cId <= SRC_NUM) && ie[cId-1];
      if (validComp) compQ.push_back(hot(int'(cId)));
    end
    @(posedge clk);
    #1;
    claimReq = 1'b0;
    compReq = 1'b0;
    checkOutput("irq_after_claim", 32'(irq), 32'd0);
    if (withComp && !validComp) checkOutput("comp_ignored", 32'(compHot), 32'd0);
  endtask

  task automatic doComp(input logic [3:0] cId);
    bit validComp;
    compReq = 1'b1;
    compId = cId;
    validComp = (cId >= 1) && (cId <= SRC_NUM) && ie[cId-1];
    if (validComp) compQ.push_back(hot(int'(cId)));
    @(posedge clk);
    #1;
    compReq = 1'b0;
    if (!validComp) checkOutput("comp_ignored", 32'(compHot), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          got;
    bit          seen;
    logic [7:0]  nIp;
    logic [7:0]  nIe;
    logic [23:0] nPrio;
    logic [2:0]  nTh;

    ie = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_claim_vld", 32'(claimVld), 32'd0);
    checkOutput("rst_claim_id", 32'(claimId), 32'd0);
    checkOutput("rst_claim_o", 32'(claimHot), 32'd0);
    checkOutput("rst_comp_o", 32'(compHot), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    rstN = 1'b1;

    // Idle sources: irq stays low over three sweeps and a claim returns 0.
    for (int i = 0; i < 3 * SRC_NUM; i++) begin
      @(posedge clk);
      #1;
      checkOutput("idle_irq", 32'(irq), 32'd0);
    end
    doClaim(8'hFF, 1'b0, 4'd0, 1'b0, got);

    // Single source 3 and a tie between sources 2 and 5.
    applyStimulus(8'h04, 8'hFF, 24'o00000500, 3'd2);
    doClaim(8'hFF, 1'b0, 4'd0, 1'b0, got);
    applyStimulus(8'h12, 8'hFF, 24'o00040040, 3'd0);
    doClaim(8'hFF, 1'b0, 4'd0, 1'b0, got);
    applyStimulus(8'h10, 8'hFF, 24'o00040040, 3'd0);
    doClaim(8'hFF, 1'b0, 4'd0, 1'b0, got);

    // Threshold boundary on source 6.
    applyStimulus(8'h20, 8'hFF, 24'o00300000, 3'd3);
    thold = 3'd2;
    seen = 1'b0;
    for (int i = 0; i < IRQ_BOUND && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = irq;
    end
    checkOutput("irq_rise_latency", 32'(seen), 32'd1);
    thold = 3'd7;
    @(posedge clk);
    #1;
    checkOutput("irq_drop_thold", 32'(irq), 32'd0);

    // Enable withdrawn in the claim cycle.
    applyStimulus(8'h08, 8'hFF, 24'o00006000, 3'd0);
    doClaim(8'hF7, 1'b0, 4'd0, 1'b0, got);

    // Completes: valid, out of range, and alongside a claim.
    applyStimulus(8'h00, 8'hFF, 24'o00000000, 3'd0);
    doComp(4'd6);
    doComp(4'd0);
    doComp(4'd9);
    applyStimulus(8'h04, 8'hFF, 24'o00000500, 3'd2);
    doClaim(8'hFF, 1'b1, 4'd6, 1'b0, got);

    // Reset mid-sweep must drop the committed winner.
    applyStimulus(8'h08, 8'hFF, 24'o00006000, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    checkOutput("irq_after_reset", 32'(irq), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("irq_first_sweep", 32'(irq), 32'd0);
    end
    doClaim(8'hFF, 1'b0, 4'd0, 1'b1, got);

    // Randomized rounds, sometimes keeping the pending set minus the claimed source.
    nIp = '0;
    nIe = 8'hFF;
    nPrio = '0;
    nTh = '0;
    for (int it = 0; it < 40; it++) begin
      if (it == 0 || $urandom_range(0, 1) == 1) begin
        nIp   = 8'($urandom);
        nIe   = 8'($urandom) | 8'($urandom);
        nPrio = 24'($urandom);
        nTh   = 3'($urandom_range(0, 4));
      end else begin
        nIp = nIp & ~hot(got);
      end
      applyStimulus(nIp, nIe, nPrio, nTh);
      doClaim(($urandom_range(0, 3) == 0) ? 8'($urandom) : nIe, 1'($urandom),
              4'($urandom_range(0, 15)), 1'b0, got);
      nIe = ie;
      if ($urandom_range(0, 3) == 0) begin
        int dummy;
        doClaim(nIe, 1'b0, 4'd0, 1'b1, dummy);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("claim_queue_drained", 32'(claimQ.size()), 32'd0);
    checkOutput("comp_queue_drained", 32'(compQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
